// File: rtl/f1_reaction_ctrl.sv
// f1_reaction_ctrl: F1 start-light race controller.
// Pulses the light block trigger, follows the light pattern, flags jump starts
// and measures lights-out-to-press reaction time in prescaled ticks.
// Optional feature macro: F1_BEST_TIME_EN (best-time register; otherwise
// o_best_time is tied to all-ones).
module f1_reaction_ctrl #(
    parameter int unsigned TICK_N = 54,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ARM_TO = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_press,
    input  logic [7:0]       i_lights,
    output logic             o_trigger,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_react_time,
    output logic             o_react_valid,
    output logic             o_jump_start,
    output logic [CNT_W-1:0] o_best_time
);

    localparam int unsigned PW = (TICK_N > 0) ? $clog2(TICK_N + 1) : 1;
    localparam int unsigned AW = (ARM_TO > 1) ? $clog2(ARM_TO + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SEQ,
        S_TIMING,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic             r_start_q;
    logic             r_press_q;
    logic [7:0]       r_lights_q;
    logic [AW-1:0]    r_arm_cnt;
    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trigger;
    logic [CNT_W-1:0] r_react_time;
    logic             r_react_valid;
    logic             r_jump_start;
`ifdef F1_BEST_TIME_EN
    logic [CNT_W-1:0] r_best_time;
`endif

    logic w_start_re;
    logic w_press_re;

    assign w_start_re = i_start & ~r_start_q;
    assign w_press_re = i_press & ~r_press_q;

    // Race sequencing FSM with edge-detect, light history and reaction timer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b0;
            r_press_q     <= 1'b0;
            r_lights_q    <= '0;
            r_arm_cnt     <= '0;
            r_presc       <= '0;
            r_cnt         <= '0;
            r_trigger     <= 1'b0;
            r_react_time  <= '0;
            r_react_valid <= 1'b0;
            r_jump_start  <= 1'b0;
`ifdef F1_BEST_TIME_EN
            r_best_time   <= '1;
`endif
        end else begin
            r_start_q     <= i_start;
            r_press_q     <= i_press;
            r_lights_q    <= i_lights;
            r_trigger     <= 1'b0;
            r_react_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_FAULT: begin
                    if (w_start_re) begin
                        r_trigger    <= 1'b1;
                        r_jump_start <= 1'b0;
                        r_arm_cnt    <= '0;
                        r_state      <= S_ARM;
                    end
                end
                S_ARM: begin
                    // a press before any light is a jump start even if lights appear in the same cycle
                    if (w_press_re) begin
                        r_jump_start <= 1'b1;
                        r_state      <= S_FAULT;
                    end else if (i_lights != 8'h00) begin
                        r_state <= S_SEQ;
                    end else if (r_arm_cnt == AW'(ARM_TO - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                S_SEQ: begin
                    if (w_press_re) begin
                        r_jump_start <= 1'b1;
                        r_state      <= S_FAULT;
                    end else if (i_lights == 8'h00) begin
                        if (r_lights_q == 8'hFF) begin
                            r_presc <= '0;
                            r_cnt   <= '0;
                            r_state <= S_TIMING;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_TIMING: begin
                    if (w_press_re) begin
                        r_react_time  <= r_cnt;
                        r_react_valid <= 1'b1;
`ifdef F1_BEST_TIME_EN
                        if (r_cnt < r_best_time) begin
                            r_best_time <= r_cnt;
                        end
`endif
                        r_state <= S_DONE;
                    end else if (r_presc == PW'(TICK_N)) begin
                        r_presc <= '0;
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!i_start && !i_press) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_trigger     = r_trigger;
    assign o_busy        = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign o_react_time  = r_react_time;
    assign o_react_valid = r_react_valid;
    assign o_jump_start  = r_jump_start;
`ifdef F1_BEST_TIME_EN
    assign o_best_time   = r_best_time;
`else
    assign o_best_time   = '1;
`endif

endmodule
